// File: rtl/main_control_fsm.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with memory-ready stalls.
// Define ILLEGAL_OP_TRAP_EN to send illegal opcodes to a sticky TRAP state instead of treating them as NOPs.
module main_control_fsm #(
    parameter int unsigned RESET_STATE_IDLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] instr_op,
    input  logic       mem_ready,
    input  logic       zero,
    output logic [4:0] op_code,
    output logic [4:0] alu_code,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_b,
    output logic       halted,
    output logic       trap
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam state_t RESET_STATE = (RESET_STATE_IDLE != 0) ? S_IDLE : S_FETCH;

    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b01001;
    localparam logic [4:0] OP_BEQ  = 5'b01010;
    localparam logic [4:0] OP_JMP  = 5'b01011;
    localparam logic [4:0] OP_LI   = 5'b01100;
    localparam logic [4:0] OP_ADDI = 5'b01101;
    localparam logic [4:0] OP_CMP  = 5'b01110;
    localparam logic [4:0] OP_HALT = 5'b11111;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_op;

    logic w_is_rtype;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_beq;
    logic w_is_jmp;
    logic w_is_li;
    logic w_is_addi;
    logic w_is_cmp;
    logic w_is_halt;
    logic w_is_legal;

    always_comb begin
        w_is_rtype = (r_op[4:3] == 2'b00);
        w_is_lw    = (r_op == OP_LW);
        w_is_sw    = (r_op == OP_SW);
        w_is_beq   = (r_op == OP_BEQ);
        w_is_jmp   = (r_op == OP_JMP);
        w_is_li    = (r_op == OP_LI);
        w_is_addi  = (r_op == OP_ADDI);
        w_is_cmp   = (r_op == OP_CMP);
        w_is_halt  = (r_op == OP_HALT);
        w_is_legal = w_is_rtype | w_is_lw | w_is_sw | w_is_beq | w_is_jmp |
                     w_is_li | w_is_addi | w_is_cmp | w_is_halt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_STATE;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_FETCH) && mem_ready) begin
                r_op <= instr_op;
            end
        end
    end

    assign op_code = r_op;

    always_comb begin
        w_next     = r_state;
        alu_code   = '0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 2'b00;
        alu_src_b  = 2'b00;
        halted     = 1'b0;
        trap       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end

            S_FETCH: begin
                mem_req   = 1'b1;
                alu_code  = 5'b00010;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end

            S_DECODE: begin
                alu_code  = 5'b00010;
                alu_src_b = 2'b10;
                if (w_is_halt) begin
                    w_next = S_HALT;
                end else if (!w_is_legal) begin
`ifdef ILLEGAL_OP_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_next = S_FETCH;
`endif
                end else begin
                    w_next = S_EXEC;
                end
            end

            S_EXEC: begin
                if (w_is_rtype) begin
                    alu_code = 5'b00001;
                    w_next   = S_WB;
                end else if (w_is_lw || w_is_sw || w_is_addi) begin
                    alu_code  = 5'b00010;
                    alu_src_b = 2'b10;
                    w_next    = w_is_addi ? S_WB : S_MEM;
                end else if (w_is_li) begin
                    alu_code  = 5'b01000;
                    alu_src_b = 2'b10;
                    w_next    = S_WB;
                end else if (w_is_cmp) begin
                    alu_code = 5'b00100;
                    w_next   = S_WB;
                end else if (w_is_beq) begin
                    alu_code = 5'b10000;
                    pc_src   = 2'b01;
                    pc_write = zero;
                    w_next   = S_FETCH;
                end else if (w_is_jmp) begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    // Unreachable for decoded opcodes; recover without side effects.
                    w_next = S_FETCH;
                end
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_is_sw;
                if (mem_ready) begin
                    w_next = w_is_sw ? S_FETCH : S_WB;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = w_is_lw;
                w_next     = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            S_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
                trap = 1'b1;
`else
                w_next = S_FETCH;
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: per-cycle expected output vectors are queued, then popped and compared.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ready;
    logic       zero;
    logic [4:0] instr_op;

    logic [4:0] op_code, alu_code;
    logic       ir_write, pc_write, mem_req, mem_we, reg_write, mem_to_reg, halted, trap;
    logic [1:0] pc_src, alu_src_b;

    logic [4:0] op_code_b, alu_code_b;
    logic       ir_write_b, pc_write_b, mem_req_b, mem_we_b, reg_write_b, mem_to_reg_b, halted_b, trap_b;
    logic [1:0] pc_src_b, alu_src_b_b;

    logic [21:0] obs, obs_b;

    main_control_fsm dut (
        .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready), .zero(zero),
        .op_code(op_code), .alu_code(alu_code), .ir_write(ir_write), .pc_write(pc_write),
        .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .pc_src(pc_src), .alu_src_b(alu_src_b), .halted(halted), .trap(trap)
    );

    main_control_fsm #(.RESET_STATE_IDLE(0)) dut_fetch_rst (
        .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready), .zero(zero),
        .op_code(op_code_b), .alu_code(alu_code_b), .ir_write(ir_write_b), .pc_write(pc_write_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .reg_write(reg_write_b), .mem_to_reg(mem_to_reg_b),
        .pc_src(pc_src_b), .alu_src_b(alu_src_b_b), .halted(halted_b), .trap(trap_b)
    );

    assign obs   = {op_code, alu_code, ir_write, pc_write, mem_req, mem_we, reg_write,
                    mem_to_reg, pc_src, alu_src_b, halted, trap};
    assign obs_b = {op_code_b, alu_code_b, ir_write_b, pc_write_b, mem_req_b, mem_we_b, reg_write_b,
                    mem_to_reg_b, pc_src_b, alu_src_b_b, halted_b, trap_b};

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [4:0] G = 5'b10111;

    function automatic logic [21:0] mk(input logic [4:0] op, input logic [4:0] alu,
                                       input logic irw, input logic pcw, input logic mreq,
                                       input logic mwe, input logic rw, input logic m2r,
                                       input logic [1:0] psrc, input logic [1:0] srcb,
                                       input logic hlt, input logic trp);
        return {op, alu, irw, pcw, mreq, mwe, rw, m2r, psrc, srcb, hlt, trp};
    endfunction

    function automatic logic [21:0] e_zero(input logic [4:0] op);
        return mk(op, 5'b00000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    endfunction

    function automatic logic [21:0] e_fetch(input logic [4:0] op, input logic rdy);
        return mk(op, 5'b00010, rdy, rdy, 1, 0, 0, 0, 2'b00, 2'b01, 0, 0);
    endfunction

    function automatic logic [21:0] e_dec(input logic [4:0] op);
        return mk(op, 5'b00010, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0);
    endfunction

    function automatic logic [21:0] e_exec(input logic [4:0] op, input logic [4:0] alu, input logic pcw,
                                           input logic [1:0] psrc, input logic [1:0] srcb);
        return mk(op, alu, 0, pcw, 0, 0, 0, 0, psrc, srcb, 0, 0);
    endfunction

    function automatic logic [21:0] e_mem(input logic [4:0] op, input logic we);
        return mk(op, 5'b00000, 0, 0, 1, we, 0, 0, 2'b00, 2'b00, 0, 0);
    endfunction

    function automatic logic [21:0] e_wb(input logic [4:0] op, input logic m2r);
        return mk(op, 5'b00000, 0, 0, 0, 0, 1, m2r, 2'b00, 2'b00, 0, 0);
    endfunction

    task automatic step(input string tag, input logic rdy, input logic z,
                        input logic [4:0] ins, input logic [21:0] e);
        exp_t x;
        mem_ready = rdy;
        zero      = z;
        instr_op  = ins;
        x.tag = tag;
        x.v   = e;
        sb.push_back(x);
        @(negedge clk);
        x = sb.pop_front();
        checks++;
        assert (obs === x.v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs, x.v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        instr_op  = 5'b00000;
        @(posedge clk);
        #1;

        step("reset_idle", 0, 0, G, e_zero(5'd0));
        @(negedge clk);
        checks++;
        assert (obs_b === e_fetch(5'd0, 1'b0)) else begin
            errors++;
            $error("FAIL reset_fetch_variant: observed %h expected %h", obs_b, e_fetch(5'd0, 1'b0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("idle", 0, 0, G, e_zero(5'd0));

        // R-type function 2
        step("r_fetch", 1, 0, 5'b00010, e_fetch(5'd0, 1));
        step("r_dec",   0, 0, G, e_dec(5'd2));
        step("r_exec",  0, 0, G, e_exec(5'd2, 5'b00001, 0, 2'b00, 2'b00));
        step("r_wb",    0, 0, G, e_wb(5'd2, 0));

        // LW with a fetch stall and two MEM stalls
        step("lw_fetch_stall", 0, 0, 5'b01000, e_fetch(5'd2, 0));
        step("lw_fetch", 1, 0, 5'b01000, e_fetch(5'd2, 1));
        step("lw_dec",   0, 0, G, e_dec(5'd8));
        step("lw_exec",  0, 0, G, e_exec(5'd8, 5'b00010, 0, 2'b00, 2'b10));
        step("lw_mem0",  0, 0, G, e_mem(5'd8, 0));
        step("lw_mem1",  0, 0, G, e_mem(5'd8, 0));
        step("lw_mem2",  1, 0, G, e_mem(5'd8, 0));
        step("lw_wb",    0, 0, G, e_wb(5'd8, 1));

        // BEQ taken then not taken; stray mem_ready pulses must be ignored
        step("beq1_fetch", 1, 0, 5'b01010, e_fetch(5'd8, 1));
        step("beq1_dec",   1, 0, G, e_dec(5'd10));
        step("beq1_exec",  1, 1, G, e_exec(5'd10, 5'b10000, 1, 2'b01, 2'b00));
        step("beq0_fetch", 1, 0, 5'b01010, e_fetch(5'd10, 1));
        step("beq0_dec",   0, 0, G, e_dec(5'd10));
        step("beq0_exec",  1, 0, G, e_exec(5'd10, 5'b10000, 0, 2'b01, 2'b00));

        step("jmp_fetch", 1, 0, 5'b01011, e_fetch(5'd10, 1));
        step("jmp_dec",   0, 0, G, e_dec(5'd11));
        step("jmp_exec",  0, 0, G, e_exec(5'd11, 5'b00000, 1, 2'b10, 2'b00));

        step("addi_fetch", 1, 0, 5'b01101, e_fetch(5'd11, 1));
        step("addi_dec",   0, 0, G, e_dec(5'd13));
        step("addi_exec",  0, 0, G, e_exec(5'd13, 5'b00010, 0, 2'b00, 2'b10));
        step("addi_wb",    1, 0, G, e_wb(5'd13, 0));

        step("li_fetch", 1, 0, 5'b01100, e_fetch(5'd13, 1));
        step("li_dec",   0, 0, G, e_dec(5'd12));
        step("li_exec",  0, 0, G, e_exec(5'd12, 5'b01000, 0, 2'b00, 2'b10));
        step("li_wb",    0, 0, G, e_wb(5'd12, 0));

        step("cmp_fetch", 1, 0, 5'b01110, e_fetch(5'd12, 1));
        step("cmp_dec",   0, 0, G, e_dec(5'd14));
        step("cmp_exec",  0, 0, G, e_exec(5'd14, 5'b00100, 0, 2'b00, 2'b00));
        step("cmp_wb",    0, 0, G, e_wb(5'd14, 0));

        step("r7_fetch", 1, 0, 5'b00111, e_fetch(5'd14, 1));
        step("r7_dec",   0, 0, G, e_dec(5'd7));
        step("r7_exec",  0, 0, G, e_exec(5'd7, 5'b00001, 0, 2'b00, 2'b00));
        step("r7_wb",    0, 0, G, e_wb(5'd7, 0));

        // SW aborted by reset while MEM is requesting
        step("sw_fetch", 1, 0, 5'b01001, e_fetch(5'd7, 1));
        step("sw_dec",   0, 0, G, e_dec(5'd9));
        step("sw_exec",  0, 0, G, e_exec(5'd9, 5'b00010, 0, 2'b00, 2'b10));
        step("sw_mem",   0, 0, G, e_mem(5'd9, 1));
        rst = 1'b1;
        step("sw_rst",   1, 1, G, e_zero(5'd0));
        rst = 1'b0;
        step("post_rst_idle", 1, 0, G, e_zero(5'd0));

        // Illegal opcode 10101
        step("ill_fetch", 1, 0, 5'b10101, e_fetch(5'd0, 1));
        step("ill_dec",   0, 0, G, e_dec(5'd21));
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            step("trap_hold", 1, 1, G, mk(5'd21, 5'b00000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
        end
        rst = 1'b1;
        step("trap_rst", 0, 0, G, e_zero(5'd0));
        rst = 1'b0;
        step("trap_idle", 0, 0, G, e_zero(5'd0));
        step("halt_fetch", 1, 0, 5'b11111, e_fetch(5'd0, 1));
`else
        step("halt_fetch", 1, 0, 5'b11111, e_fetch(5'd21, 1));
`endif
        step("halt_dec", 0, 0, G, e_dec(5'd31));
        for (int i = 0; i < 20; i++) begin
            step("halt_hold", logic'(i % 2), 1, G,
                 mk(5'd31, 5'b00000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
